// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, a persistent {S,Z,C,V} flag
// register and iterative one-bit-per-cycle shifts and rotates.
module alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             res_we,
  output logic             err,
  output logic [3:0]       cond
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_CMP = 4'd5,
    OP_MOV = 4'd6,
    OP_ADC = 4'd7,
    OP_SLL = 4'd8,
    OP_ROL = 4'd9,
    OP_SRL = 4'd10,
    OP_SRA = 4'd11
  } op_e;

  state_e           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] sh_q;
  logic [SHW-1:0]   cnt;

  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] res;
  logic             fv;
  logic             legal;
  logic             shift_op;
  logic             we;
  logic [SHW-1:0]   n;

  logic [WIDTH-1:0] sh_nx;
  logic             sh_c;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign n         = b[SHW-1:0];

  // Single-cycle ops evaluated on the request inputs; C is always bit WIDTH
  // of the extended result, which is 0 for logic ops, MOV and zero-length shifts.
  always_comb begin
    ext      = '0;
    fv       = 1'b0;
    legal    = 1'b1;
    shift_op = 1'b0;
    we       = 1'b1;
    case (op)
      OP_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        fv  = (a[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADC: begin
        ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cond[1]};
        fv  = (a[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        ext = {1'b0, a} - {1'b0, b};
        fv  = (a[WIDTH-1] != b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
        we  = (op != OP_CMP);
      end
      OP_AND: ext = {1'b0, a & b};
      OP_OR:  ext = {1'b0, a | b};
      OP_XOR: ext = {1'b0, a ^ b};
      OP_MOV: ext = {1'b0, b};
      OP_SLL, OP_ROL, OP_SRL, OP_SRA: begin
        shift_op = 1'b1;
        ext      = {1'b0, a};
      end
      default: begin
        legal = 1'b0;
        we    = 1'b0;
      end
    endcase
    res = ext[WIDTH-1:0];
  end

  always_comb begin
    sh_nx = sh_q;
    sh_c  = 1'b0;
    case (op_q)
      OP_SLL: {sh_c, sh_nx} = {sh_q, 1'b0};
      OP_ROL: begin
        sh_c  = sh_q[WIDTH-1];
        sh_nx = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
      end
      OP_SRL: {sh_nx, sh_c} = {1'b0, sh_q};
      default: {sh_nx, sh_c} = {sh_q[WIDTH-1], sh_q};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      sh_q   <= '0;
      cnt    <= '0;
      result <= '0;
      res_we <= 1'b0;
      err    <= 1'b0;
      cond   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!legal) begin
              result <= '0;
              res_we <= 1'b0;
              err    <= 1'b1;
              state  <= DONE;
            end else if (shift_op && (n != '0)) begin
              op_q  <= op;
              sh_q  <= a;
              cnt   <= n;
              state <= SHIFT;
            end else begin
              result <= res;
              res_we <= we;
              err    <= 1'b0;
              cond   <= {res[WIDTH-1] ^ fv, res == '0, ext[WIDTH], fv};
              state  <= DONE;
            end
          end
        end
        SHIFT: begin
          sh_q <= sh_nx;
          cnt  <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            result <= sh_nx;
            res_we <= 1'b1;
            err    <= 1'b0;
            cond   <= {sh_nx[WIDTH-1], sh_nx == '0, sh_c, 1'b0};
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            err   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a table of single operations with hand-computed
// results, followed by stall, input-capture and mid-shift reset sequences.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        res_we;
  logic        err;
  logic [3:0]  cond;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .res_we    (res_we),
    .err       (err),
    .cond      (cond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  cond;
    logic        we;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one request from IDLE, scramble the operands after acceptance and
  // wait (bounded) for out_valid; lat counts cycles from acceptance.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] aa,
                        input logic [15:0] bb, output int lat);
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op = o;
    a  = aa;
    b  = bb;
    @(negedge clk);
    in_valid = 1'b0;
    a = ~aa;
    b = ~bb;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    vecs[0]  = '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b0001, 1'b1, 1'b0, 1};
    vecs[1]  = '{4'd1,  16'h0000, 16'h0001, 16'hFFFF, 4'b1010, 1'b1, 1'b0, 1};
    vecs[2]  = '{4'd7,  16'hFFFF, 16'h0000, 16'h0000, 4'b0110, 1'b1, 1'b0, 1};
    vecs[3]  = '{4'd7,  16'h0001, 16'h0001, 16'h0003, 4'b0000, 1'b1, 1'b0, 1};
    vecs[4]  = '{4'd2,  16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000, 1'b1, 1'b0, 1};
    vecs[5]  = '{4'd3,  16'hF0F0, 16'h0F00, 16'hFFF0, 4'b1000, 1'b1, 1'b0, 1};
    vecs[6]  = '{4'd4,  16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100, 1'b1, 1'b0, 1};
    vecs[7]  = '{4'd6,  16'h1234, 16'h8001, 16'h8001, 4'b1000, 1'b1, 1'b0, 1};
    vecs[8]  = '{4'd5,  16'h0005, 16'h0005, 16'h0000, 4'b0100, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'd13, 16'h0001, 16'h0002, 16'h0000, 4'b0100, 1'b0, 1'b1, 1};
    vecs[10] = '{4'd8,  16'h1234, 16'h0000, 16'h1234, 4'b0000, 1'b1, 1'b0, 1};
    vecs[11] = '{4'd11, 16'h8001, 16'h0004, 16'hF800, 4'b1000, 1'b1, 1'b0, 5};
    vecs[12] = '{4'd9,  16'h8000, 16'h0001, 16'h0001, 4'b0010, 1'b1, 1'b0, 2};
    vecs[13] = '{4'd10, 16'h8001, 16'h0001, 16'h4000, 4'b0010, 1'b1, 1'b0, 2};
    vecs[14] = '{4'd8,  16'h0001, 16'h000F, 16'h8000, 4'b1000, 1'b1, 1'b0, 16};
    vecs[15] = '{4'd9,  16'h1234, 16'h0014, 16'h2341, 4'b0010, 1'b1, 1'b0, 5};
    vecs[16] = '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b1001, 1'b1, 1'b0, 1};
    vecs[17] = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1'b1, 1'b0, 1};
    vecs[18] = '{4'd11, 16'h7FF0, 16'h0003, 16'h0FFE, 4'b0000, 1'b1, 1'b0, 4};
    vecs[19] = '{4'd10, 16'h000F, 16'h0002, 16'h0003, 4'b0010, 1'b1, 1'b0, 3};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.result", 32'(result), 32'd0);
    chk("reset.res_we", 32'(res_we), 32'd0);
    chk("reset.err", 32'(err), 32'd0);
    chk("reset.cond", 32'(cond), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      run_op(tag, vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk({tag, ".latency"}, 32'(lat), 32'(vecs[i].lat));
      chk({tag, ".result"}, 32'(result), 32'(vecs[i].res));
      chk({tag, ".cond"}, 32'(cond), 32'(vecs[i].cond));
      chk({tag, ".res_we"}, 32'(res_we), 32'(vecs[i].we));
      chk({tag, ".err"}, 32'(err), 32'(vecs[i].err));
      consume();
      chk({tag, ".err_cleared"}, 32'(err), 32'd0);
    end

    // SRA with a stalled consumer and in_valid left high with changing operands
    @(negedge clk);
    in_valid = 1'b1;
    op = 4'd11;
    a  = 16'h8001;
    b  = 16'h0004;
    @(negedge clk);
    a = 16'h0000;
    b = 16'h0000;
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("stall.busy_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk("stall.latency", 32'(lat), 32'd5);
    for (int k = 0; k < 4; k++) begin
      chk("stall.result", 32'(result), 32'hF800);
      chk("stall.cond", 32'(cond), 32'b1000);
      chk("stall.out_valid", 32'(out_valid), 32'd1);
      chk("stall.in_ready", 32'(in_ready), 32'd0);
      if (k < 3) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("stall.idle_in_ready", 32'(in_ready), 32'd1);
    chk("stall.idle_out_valid", 32'(out_valid), 32'd0);

    // Reset during the second SHIFT cycle of SLL by 8
    @(negedge clk);
    in_valid = 1'b1;
    op = 4'd8;
    a  = 16'h00FF;
    b  = 16'h0008;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstmid.shift1_out_valid", 32'(out_valid), 32'd0);
    chk("rstmid.shift1_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid.in_ready", 32'(in_ready), 32'd1);
    chk("rstmid.out_valid", 32'(out_valid), 32'd0);
    chk("rstmid.cond", 32'(cond), 32'd0);
    chk("rstmid.result", 32'(result), 32'd0);
    repeat (20) begin
      @(negedge clk);
      chk("rstmid.no_late_valid", 32'(out_valid), 32'd0);
    end
    run_op("after_rst", 4'd0, 16'h0003, 16'h0004, lat);
    chk("after_rst.latency", 32'(lat), 32'd1);
    chk("after_rst.result", 32'(result), 32'd7);
    chk("after_rst.cond", 32'(cond), 32'b0000);
    chk("after_rst.res_we", 32'(res_we), 32'd1);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
